// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Purpose:
//   Hazard detection and operand forwarding for a 5-stage in-order pipeline
//   (F, D, E, M, W). The unit keeps its own shadow of the register-usage fields
//   of the instructions sitting in E, M and W. It derives three things from that
//   shadow and the decode-stage inputs: load-use stalls, branch flushes and ALU
//   forwarding selects.
//
// Ports:
//   clk           in   1   pipeline clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   rs1_d         in   5   decode-stage source register 1
//   rs2_d         in   5   decode-stage source register 2
//   rd_d          in   5   decode-stage destination register
//   reg_write_d   in   1   decode instruction writes the register file
//   result_src_d  in   2   decode result select, 2'b01 = load from memory
//   pc_src_e      in   1   execute-stage branch/jump taken
//   stall_f       out  1   hold PC
//   stall_d       out  1   hold F->D register
//   flush_d       out  1   clear F->D register
//   flush_e       out  1   clear D->E register (insert bubble)
//   forward_a_e   out  2   operand A select: 00 rd1_e, 01 W result, 10 M ALU result
//   forward_b_e   out  2   operand B select, same encoding
//   stall_count   out  32  (HAZARD_PERF_EN only) saturating count of stall_d cycles
//   flush_count   out  32  (HAZARD_PERF_EN only) saturating count of flush_d cycles
//
// Build option:
//   HAZARD_PERF_EN  when defined, adds the stall_count/flush_count performance
//                   counters. When undefined, those ports and counters do not exist.
// -----------------------------------------------------------------------------
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic        reg_write_d,
    input  logic [1:0]  result_src_d,
    input  logic        pc_src_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  forward_a_e,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
`endif
    output logic [1:0]  forward_b_e
);

    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] FWD_NONE    = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;

    // Shadow of the in-flight instructions
    logic [4:0] e_rs1;
    logic [4:0] e_rs2;
    logic [4:0] e_rd;
    logic       e_reg_write;
    logic [1:0] e_result_src;
    logic [4:0] m_rd;
    logic       m_reg_write;
    logic [4:0] w_rd;
    logic       w_reg_write;

    logic       lw_stall;
    logic       bubble_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Select the newest in-flight producer of src. M is checked first because it
    // holds the younger of the two producers. x0 is never a producer, even when a
    // shadow entry carries reg_write=1 with rd=0.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_dst,
        input logic       m_we,
        input logic [4:0] w_dst,
        input logic       w_we
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (m_we && (m_dst != 5'd0) && (m_dst == src))
            sel = FWD_M;
        else if (w_we && (w_dst != 5'd0) && (w_dst == src))
            sel = FWD_W;
        return sel;
    endfunction

    // A load in E whose result a decode source needs must wait one cycle. The
    // load then reaches M while the consumer waits in D. On the next cycle the
    // consumer enters E with the load in W, and it picks the value up through
    // the W forward path.
    always_comb begin
        lw_stall = 1'b0;
        if ((e_result_src == RESULT_LOAD) && e_reg_write && (e_rd != 5'd0) &&
            ((e_rd == rs1_d) || (e_rd == rs2_d)))
            lw_stall = 1'b1;
    end

    // Bubble decision used by the shadow register itself. It is the ungated form
    // of flush_e. During reset the shadow is held clear asynchronously anyway.
    assign bubble_e = lw_stall | pc_src_e;

    always_comb begin
        fwd_a = fwd_sel(e_rs1, m_rd, m_reg_write, w_rd, w_reg_write);
        fwd_b = fwd_sel(e_rs2, m_rd, m_reg_write, w_rd, w_reg_write);
    end

    // Outputs are forced quiet during reset. flush_d follows pc_src_e directly,
    // so it needs this gate. The other outputs are already zero because the
    // shadow is zero. A taken branch takes priority over a load-use stall: the
    // stalled consumer is on the wrong path and is flushed instead.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        forward_a_e = FWD_NONE;
        forward_b_e = FWD_NONE;
        if (!rst) begin
            stall_f     = lw_stall & ~pc_src_e;
            stall_d     = lw_stall & ~pc_src_e;
            flush_d     = pc_src_e;
            flush_e     = bubble_e;
            forward_a_e = fwd_a;
            forward_b_e = fwd_b;
        end
    end

    // The shadow advances every cycle, because the real pipeline registers from
    // E onward never stall. E takes either the decode fields or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rs1        <= 5'd0;
            e_rs2        <= 5'd0;
            e_rd         <= 5'd0;
            e_reg_write  <= 1'b0;
            e_result_src <= 2'b00;
            m_rd         <= 5'd0;
            m_reg_write  <= 1'b0;
            w_rd         <= 5'd0;
            w_reg_write  <= 1'b0;
        end else begin
            w_rd        <= m_rd;
            w_reg_write <= m_reg_write;
            m_rd        <= e_rd;
            m_reg_write <= e_reg_write;
            if (bubble_e) begin
                e_rs1        <= 5'd0;
                e_rs2        <= 5'd0;
                e_rd         <= 5'd0;
                e_reg_write  <= 1'b0;
                e_result_src <= 2'b00;
            end else begin
                e_rs1        <= rs1_d;
                e_rs2        <= rs2_d;
                e_rd         <= rd_d;
                e_reg_write  <= reg_write_d;
                e_result_src <= result_src_d;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters. Each counter holds at all-ones and does not
    // wrap, so a long-running count is never misread as a small one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall_d && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (flush_d && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        reg_write_d;
    logic [1:0]  result_src_d;
    logic        pc_src_e;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  forward_a_e, forward_b_e;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .reg_write_d  (reg_write_d),
        .result_src_d (result_src_d),
        .pc_src_e     (pc_src_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .forward_a_e  (forward_a_e),
`ifdef HAZARD_PERF_EN
        .stall_count  (stall_count),
        .flush_count  (flush_count),
`endif
        .forward_b_e  (forward_b_e)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instruction that enters E is recorded. Slot 0 is the instruction now
    // in E, slot 1 is one cycle older (M) and slot 2 is two cycles older (W).
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic [1:0] src;
    } ins_t;

    ins_t hist [3];
`ifdef HAZARD_PERF_EN
    logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

    function automatic logic m_load_use(input ins_t e, input logic [4:0] a, input logic [4:0] b);
        return (e.src == 2'b01) && e.we && (e.rd != 0) && (e.rd == a || e.rd == b);
    endfunction

    // Search backwards in age for the youngest older instruction writing src.
    // Age 1 (the instruction in M) gives 2'b10; age 2 (in W) gives 2'b01.
    function automatic logic [1:0] m_fwd(input logic [4:0] src, input ins_t m, input ins_t w);
        ins_t older [2];
        older[0] = m;
        older[1] = w;
        for (int age = 1; age <= 2; age++) begin
            if (older[age-1].we && older[age-1].rd != 0 && older[age-1].rd == src)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] <= '0;
`ifdef HAZARD_PERF_EN
            m_stall_cnt <= 0;
            m_flush_cnt <= 0;
`endif
        end else begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            if (m_load_use(hist[0], rs1_d, rs2_d) || pc_src_e)
                hist[0] <= '0;
            else
                hist[0] <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, we: reg_write_d, src: result_src_d};
`ifdef HAZARD_PERF_EN
            if (m_load_use(hist[0], rs1_d, rs2_d) && !pc_src_e && m_stall_cnt != 32'hFFFF_FFFF)
                m_stall_cnt <= m_stall_cnt + 1;
            if (pc_src_e && m_flush_cnt != 32'hFFFF_FFFF)
                m_flush_cnt <= m_flush_cnt + 1;
`endif
        end
    end

    // Compare process: checks the DUT against the model on every falling edge.
    logic exp_lu, exp_stall;
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {26'd0, stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e}, 32'd0);
        end else begin
            exp_lu    = m_load_use(hist[0], rs1_d, rs2_d);
            exp_stall = exp_lu & ~pc_src_e;
            chk("stall_f", {31'd0, stall_f}, {31'd0, exp_stall});
            chk("stall_d", {31'd0, stall_d}, {31'd0, exp_stall});
            chk("flush_d", {31'd0, flush_d}, {31'd0, pc_src_e});
            chk("flush_e", {31'd0, flush_e}, {31'd0, exp_lu | pc_src_e});
            chk("forward_a_e", {30'd0, forward_a_e}, {30'd0, m_fwd(hist[0].rs1, hist[1], hist[2])});
            chk("forward_b_e", {30'd0, forward_b_e}, {30'd0, m_fwd(hist[0].rs2, hist[1], hist[2])});
        end
`ifdef HAZARD_PERF_EN
        chk("stall_count", stall_count, m_stall_cnt);
        chk("flush_count", flush_count, m_flush_cnt);
`endif
    end

    // ---------------- directed stimulus ----------------
    // Presents one decode-stage instruction for one cycle. The task returns just
    // after the falling edge, so the caller can check outputs for that cycle.
    task automatic cyc(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic w, input logic [1:0] s, input logic p);
        @(posedge clk);
        #1;
        rs1_d = a; rs2_d = b; rd_d = d; reg_write_d = w; result_src_d = s; pc_src_e = p;
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0; result_src_d = 0; pc_src_e = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_flush_d_gated", {31'd0, flush_d}, 32'd0);
        pc_src_e = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;

        // Load-use: lw x5, then a use of x5
        cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b0);
        chk("lu_c0_stall_d", {31'd0, stall_d}, 32'd0);
        cyc(5'd5, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
        chk("lu_c1_stall_f", {31'd0, stall_f}, 32'd1);
        chk("lu_c1_stall_d", {31'd0, stall_d}, 32'd1);
        chk("lu_c1_flush_e", {31'd0, flush_e}, 32'd1);
        cyc(5'd5, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
        chk("lu_c2_stall_d", {31'd0, stall_d}, 32'd0);
        nop();
        chk("lu_c3_fwd_a", {30'd0, forward_a_e}, 32'd1);

        // ALU back-to-back: add x3, sub uses rs2=x3
        cyc(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0);
        cyc(5'd4, 5'd3, 5'd8, 1'b1, 2'b00, 1'b0);
        chk("alu_stall_d", {31'd0, stall_d}, 32'd0);
        nop();
        chk("alu_fwd_b", {30'd0, forward_b_e}, 32'd2);

        // Double hazard on x4: the newer producer must win
        cyc(5'd1, 5'd1, 5'd4, 1'b1, 2'b00, 1'b0);
        cyc(5'd2, 5'd2, 5'd4, 1'b1, 2'b00, 1'b0);
        cyc(5'd4, 5'd0, 5'd9, 1'b1, 2'b00, 1'b0);
        nop();
        chk("double_fwd_a", {30'd0, forward_a_e}, 32'd2);

        // x0: lw x0 followed by a use of x0
        cyc(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0);
        cyc(5'd0, 5'd0, 5'd10, 1'b1, 2'b00, 1'b0);
        chk("x0_stall_d", {31'd0, stall_d}, 32'd0);
        nop();
        chk("x0_fwd_a", {30'd0, forward_a_e}, 32'd0);

        // Taken branch at the same time as a load-use condition
        cyc(5'd1, 5'd2, 5'd6, 1'b1, 2'b01, 1'b0);
        cyc(5'd6, 5'd0, 5'd11, 1'b1, 2'b00, 1'b1);
        chk("sim_stall_f", {31'd0, stall_f}, 32'd0);
        chk("sim_stall_d", {31'd0, stall_d}, 32'd0);
        chk("sim_flush_d", {31'd0, flush_d}, 32'd1);
        chk("sim_flush_e", {31'd0, flush_e}, 32'd1);
        cyc(5'd6, 5'd0, 5'd11, 1'b1, 2'b00, 1'b0);
        chk("sim_bubble_stall_d", {31'd0, stall_d}, 32'd0);
        chk("sim_bubble_flush_e", {31'd0, flush_e}, 32'd0);

        // Mixed vectors over a small register set. The model checks every cycle.
        for (int i = 0; i < 200; i++) begin
            cyc(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        nop();

        // Reset asserted in the middle of a load-use stall
        cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b0);
        cyc(5'd5, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
        chk("rst_pre_stall_d", {31'd0, stall_d}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {26'd0, stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rst_mid_stall_count", stall_count, 32'd0);
`endif
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_release_stall_d", {31'd0, stall_d}, 32'd0);
        chk("rst_release_flush_e", {31'd0, flush_e}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            cyc(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b0);
            cyc(5'd5, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
            chk("forced_stall_d", {31'd0, stall_d}, 32'd1);
            cyc(5'd5, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0);
        end
        nop();
`ifdef HAZARD_PERF_EN
        chk("forced_stall_count", stall_count, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have these ports:
  clk  in  1  pipeline clock, rising edge
  rst  in  1  asynchronous active-high reset
  rs1_d  in  5  decode-stage source register 1
  rs2_d  in  5  decode-stage source register 2
  rd_d  in  5  decode-stage destination register
  reg_write_d  in  1  decode instruction writes register file
  result_src_d  in  2  decode result select; 2'b01 = load from memory
  pc_src_e  in  1  execute-stage branch/jump taken
  stall_f  out  1  hold PC
  stall_d  out  1  hold F->D register
  flush_d  out  1  clear F->D register
  flush_e  out  1  clear D->E register (bubble)
  forward_a_e  out  2  ALU operand A select: 00 rd1_e, 01 W result, 10 M ALU result
  forward_b_e  out  2  ALU operand B select, same encoding
REQ-002 SHALL use one clock (clk) and an asynchronous, active-high reset (rst).

Function
REQ-003 SHALL keep an internal shadow of in-flight instructions: E {rs1, rs2, rd, reg_write, result_src}, M {rd, reg_write}, W {rd, reg_write}.
REQ-004 Each rising clk SHALL advance W<=M and M<=E.
REQ-005 Each rising clk SHALL load E from the decode inputs, or with all-zero fields (bubble) when flush_e=1.
REQ-006 lw_stall SHALL be asserted when all of the following hold: E.result_src==2'b01, E.reg_write=1, E.rd!=0, and E.rd equals rs1_d or rs2_d.
REQ-007 stall_f and stall_d SHALL equal lw_stall & ~pc_src_e, so a taken branch overrides a load-use stall.
REQ-008 flush_d SHALL equal pc_src_e.
REQ-009 flush_e SHALL equal lw_stall | pc_src_e.
REQ-010 Stall and flush outputs SHALL be combinational from the current shadow and inputs, with zero-cycle latency.
REQ-011 forward_a_e SHALL be:
  10 if M.reg_write & M.rd!=0 & M.rd==E.rs1;
  else 01 if W.reg_write & W.rd!=0 & W.rd==E.rs1;
  else 00.
REQ-012 forward_b_e SHALL follow the same rule using E.rs2.
REQ-013 When M and W both match, M priority SHALL apply (newest value wins).
REQ-014 Register x0 SHALL never trigger a stall or a forward, even if a shadow entry has reg_write=1 and rd=0.
REQ-015 After a load-use stall, the load SHALL reach M while the consumer sits in D. On the next cycle the consumer enters E with no stall, and the load is in W, giving forward=01.

Reset
REQ-016 While rst=1, all shadow fields SHALL be 0, asynchronously.
REQ-017 While rst=1, all outputs SHALL be 0: no stall, no flush, forward=00.
REQ-018 Reset asserted mid-stall SHALL cancel the stall immediately, with no residual bubble after release.

Configuration
REQ-019 With macro HAZARD_PERF_EN defined, the block SHALL add outputs stall_count[31:0] and flush_count[31:0].
REQ-020 Under HAZARD_PERF_EN, stall_count SHALL increment once per cycle with stall_d=1, and flush_count once per cycle with flush_d=1.
REQ-021 Under HAZARD_PERF_EN, both counters SHALL saturate at 32'hFFFFFFFF and reset to 0.
REQ-022 Without HAZARD_PERF_EN, the counter ports and logic SHALL be absent, with all other behaviour identical.

Verification
REQ-023 Load-use: cycle0 D=lw x5 (result_src=01, rd=5); cycle1 D rs1=5 -> cycle1 stall_f=stall_d=flush_e=1, cycle2 no stall, forward_a_e=01 in cycle3.
REQ-024 ALU back-to-back: add x3 then sub rs2=3 -> no stall; forward_b_e=10 when sub is in E.
REQ-025 Double hazard: x4 written by instructions k and k+1, read by k+2 -> forward_a_e=10, not 01.
REQ-026 x0 case: lw x0 followed by use of rs1=0 -> no stall, forward=00.
REQ-027 Simultaneous: pc_src_e=1 while lw_stall condition true -> stall_f=stall_d=0, flush_d=flush_e=1; E bubble next cycle.
REQ-028 Reset mid-stall: rst=1 during stall -> all outputs 0 at once; with HAZARD_PERF_EN, stall_count=0, and 3 forced stalls afterwards -> stall_count=3.
